// File: rtl/reg_dump_overlay.sv
// Register dump text overlay: one "Rk=HH.." line per register, with per-frame snapshot, freeze and change highlight.
// Latency: 3 clocks from x/y/video_on to rgb; rom_addr is presented 1 clock after x/y.
// Backpressure: none; this is a free-running pixel stream with no stall path.
module reg_dump_overlay #(
  parameter int          NUM_REGS    = 8,
  parameter int          DATA_W      = 8,
  parameter int          X0          = 192,
  parameter int          Y0          = 208,
  parameter int          HOLD_FRAMES = 30,
  parameter logic [11:0] FG_RGB      = 12'h00F,
  parameter logic [11:0] HL_RGB      = 12'hF00,
  parameter logic [11:0] BG_RGB      = 12'hFFF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         frame_tick,
  input  logic                         freeze,
  input  logic                         video_on,
  input  logic [9:0]                   x,
  input  logic [9:0]                   y,
  input  logic [NUM_REGS*DATA_W-1:0]   reg_flat,
  output logic [10:0]                  rom_addr,
  input  logic [7:0]                   rom_data,
  output logic [11:0]                  rgb
);

  localparam int NIB  = DATA_W / 4;
  localparam int COLS = 3 + NIB;

  // Window bounds widened to 11 bits so the right/bottom edge never wraps.
  localparam logic [10:0] X_LO = 11'(X0);
  localparam logic [10:0] X_HI = 11'(X0 + 8 * COLS);
  localparam logic [10:0] Y_LO = 11'(Y0);
  localparam logic [10:0] Y_HI = 11'(Y0 + 16 * NUM_REGS);

  // Per-pixel side information that travels alongside the glyph ROM read.
  typedef struct packed {
    logic       von;
    logic       in_win;
    logic       hl;
    logic [2:0] bit_idx;
  } pix_meta_t;

  logic [DATA_W-1:0] shadow [NUM_REGS];
  logic [7:0]        hold   [NUM_REGS];
  logic              primed;

  logic [9:0]        dx;
  logic [9:0]        dy;
  logic              in_win;
  logic [6:0]        col;
  logic [5:0]        line;
  logic [DATA_W-1:0] line_val;
  logic              line_hl;
  logic [3:0]        nib;
  logic [6:0]        ascii;
  pix_meta_t         meta_s1;
  pix_meta_t         meta_s2;
  logic              glyph_px;

  function automatic logic [6:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) return 7'h30 + {3'b000, n};
    return 7'h41 + {3'b000, n - 4'd10};
  endfunction

  assign dx     = x - 10'(X0);
  assign dy     = y - 10'(Y0);
  assign col    = dx[9:3];
  assign line   = dy[9:4];
  assign in_win = ({1'b0, x} >= X_LO) && ({1'b0, x} < X_HI) &&
                  ({1'b0, y} >= Y_LO) && ({1'b0, y} < Y_HI);

  // Select the shadowed value and highlight state of the line under the beam.
  always_comb begin
    line_val = '0;
    line_hl  = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (line == 6'(r)) begin
        line_val = shadow[r];
        line_hl  = (hold[r] != 8'd0);
      end
    end
  end

  // Pick the nibble for value columns; column 3 is the most significant nibble.
  always_comb begin
    nib = '0;
    for (int j = 0; j < NIB; j++) begin
      if (col == 7'(COLS - 1 - j)) nib = line_val[j*4 +: 4];
    end
  end

  // Character for the current cell; blank outside the window.
  always_comb begin
    ascii = 7'h00;
    if (in_win) begin
      case (col)
        7'd0:    ascii = 7'h52;
        7'd1:    ascii = hex_ascii(line[3:0]);
        7'd2:    ascii = 7'h3D;
        default: ascii = hex_ascii(nib);
      endcase
    end
  end

  // Frame snapshot and highlight countdown; a reload wins over the decrement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        shadow[r] <= '0;
        hold[r]   <= '0;
      end
      primed <= 1'b0;
    end else if (frame_tick) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (!freeze) shadow[r] <= reg_flat[r*DATA_W +: DATA_W];
        if (!freeze && primed && (reg_flat[r*DATA_W +: DATA_W] != shadow[r]))
          hold[r] <= 8'(HOLD_FRAMES);
        else if (hold[r] != 8'd0)
          hold[r] <= hold[r] - 8'd1;
      end
      if (!freeze) primed <= 1'b1;
    end
  end

  // Stage 1: glyph address and pixel side info.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr <= '0;
      meta_s1  <= '0;
    end else begin
      rom_addr        <= {ascii, dy[3:0]};
      meta_s1.von     <= video_on;
      meta_s1.in_win  <= in_win;
      meta_s1.hl      <= in_win & line_hl;
      meta_s1.bit_idx <= dx[2:0];
    end
  end

  // Stage 2: hold side info while the ROM read completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) meta_s2 <= '0;
    else        meta_s2 <= meta_s1;
  end

  assign glyph_px = rom_data[3'd7 - meta_s2.bit_idx];

  // Stage 3: colour resolve.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    rgb <= 12'h000;
    else if (!meta_s2.von)         rgb <= 12'h000;
    else if (!meta_s2.in_win)      rgb <= BG_RGB;
    else if (!glyph_px)            rgb <= BG_RGB;
    else if (meta_s2.hl)           rgb <= HL_RGB;
    else                           rgb <= FG_RGB;
  end

endmodule

// File: tb/tb_reg_dump_overlay.sv
// Bench for reg_dump_overlay: default instance plus a 16 x 32-bit instance on the same raster.
// Expected pixels come from a text-level model of each line and a synthetic glyph ROM.
// Scoreboard queues are stamped with the cycle the output is due.
module tb_reg_dump_overlay;

  localparam int          X0   = 192;
  localparam int          Y0   = 208;
  localparam int          HOLD = 30;
  localparam logic [11:0] FG   = 12'h00F;
  localparam logic [11:0] HL   = 12'hF00;
  localparam logic [11:0] BG   = 12'hFFF;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         frame_tick = 1'b0;
  logic         freeze = 1'b0;
  logic         video_on = 1'b0;
  logic [9:0]   x = '0;
  logic [9:0]   y = '0;
  logic [31:0]  regs [2][16];
  logic [63:0]  flat0;
  logic [511:0] flat1;
  logic [10:0]  rom_addr0, rom_addr1;
  logic [7:0]   rom_data0, rom_data1;
  logic [11:0]  rgb0, rgb1;

  always #5 clk = ~clk;

  always_comb begin
    flat0 = '0;
    flat1 = '0;
    for (int k = 0; k < 8; k++)  flat0[k*8 +: 8]   = regs[0][k][7:0];
    for (int k = 0; k < 16; k++) flat1[k*32 +: 32] = regs[1][k];
  end

  function automatic logic [7:0] font(input logic [10:0] a);
    logic [31:0] h;
    h = {21'b0, a} * 32'h9E3779B1;
    return h[23:16] ^ h[31:24];
  endfunction

  always @(posedge clk) rom_data0 <= font(rom_addr0);
  always @(posedge clk) rom_data1 <= font(rom_addr1);

  reg_dump_overlay dut0 (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .freeze(freeze),
    .video_on(video_on), .x(x), .y(y), .reg_flat(flat0),
    .rom_addr(rom_addr0), .rom_data(rom_data0), .rgb(rgb0)
  );

  reg_dump_overlay #(.NUM_REGS(16), .DATA_W(32)) dut1 (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .freeze(freeze),
    .video_on(video_on), .x(x), .y(y), .reg_flat(flat1),
    .rom_addr(rom_addr1), .rom_data(rom_data1), .rgb(rgb1)
  );

  // ---------------- reference model ----------------
  logic [31:0] m_sh   [2][16];
  int          m_hold [2][16];
  bit          m_primed [2];

  function automatic int nregs(int i); return (i != 0) ? 16 : 8; endfunction
  function automatic int dwid(int i);  return (i != 0) ? 32 : 8; endfunction

  function automatic string line_text(int i, int k);
    string s, t;
    s = $sformatf("%08h", m_sh[i][k]);
    t = $sformatf("R%1h=%s", k[3:0], s.substr(8 - dwid(i) / 4, 7));
    return t.toupper();
  endfunction

  function automatic void expect_pix(input int i, input int px, input int py, input bit von,
                                     output logic [11:0] rgbv, output logic [10:0] addr,
                                     output bit inw);
    int cols, k, c, r, b;
    string t;
    byte ch;
    logic [7:0] g;
    cols = 3 + dwid(i) / 4;
    inw  = (px >= X0) && (px < X0 + 8 * cols) && (py >= Y0) && (py < Y0 + 16 * nregs(i));
    addr = '0;
    rgbv = von ? BG : 12'h000;
    if (inw) begin
      k    = (py - Y0) / 16;
      c    = (px - X0) / 8;
      r    = (py - Y0) % 16;
      b    = (px - X0) % 8;
      t    = line_text(i, k);
      ch   = t[c];
      addr = {ch[6:0], 4'(r)};
      g    = font(addr);
      if (von && g[7-b]) rgbv = (m_hold[i][k] > 0) ? HL : FG;
    end
  endfunction

  task automatic model_tick(input bit frz);
    logic [31:0] nv;
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < nregs(i); k++) begin
        nv = (i == 0) ? {24'b0, regs[0][k][7:0]} : regs[1][k];
        if (!frz) begin
          if (m_primed[i] && nv != m_sh[i][k]) m_hold[i][k] = HOLD;
          else if (m_hold[i][k] > 0)           m_hold[i][k] = m_hold[i][k] - 1;
          m_sh[i][k] = nv;
        end else if (m_hold[i][k] > 0) begin
          m_hold[i][k] = m_hold[i][k] - 1;
        end
      end
      if (!frz) m_primed[i] = 1'b1;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 16; k++) begin
        m_sh[i][k]   = '0;
        m_hold[i][k] = 0;
      end
      m_primed[i] = 1'b0;
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    int          due;
    int          inst;
    int          px;
    int          py;
    logic [11:0] v;
  } exp_t;

  exp_t q_rgb[$];
  exp_t q_addr[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp,
                       input int px, input int py);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s x=%0d y=%0d got=%h want=%h t=%0t", name, px, py, act, exp, $time);
    end
  endtask

  exp_t e_mon;
  always @(negedge clk) begin
    while (q_rgb.size() > 0 && q_rgb[0].due <= cyc) begin
      e_mon = q_rgb.pop_front();
      if (e_mon.due < cyc) check("rgb_late", 12'hxxx, e_mon.v, e_mon.px, e_mon.py);
      else check((e_mon.inst != 0) ? "rgb_w32" : "rgb_w8",
                 (e_mon.inst != 0) ? rgb1 : rgb0, e_mon.v, e_mon.px, e_mon.py);
    end
    while (q_addr.size() > 0 && q_addr[0].due <= cyc) begin
      e_mon = q_addr.pop_front();
      check((e_mon.inst != 0) ? "rom_addr_w32" : "rom_addr_w8",
            (e_mon.inst != 0) ? {1'b0, rom_addr1} : {1'b0, rom_addr0},
            e_mon.v, e_mon.px, e_mon.py);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input int px, input int py, input bit von, input bit tick, input bit frz);
    logic [11:0] ev;
    logic [10:0] ea;
    bit          inw;
    x          = 10'(px);
    y          = 10'(py);
    video_on   = von;
    frame_tick = tick;
    freeze     = frz;
    for (int i = 0; i < 2; i++) begin
      expect_pix(i, px, py, von, ev, ea, inw);
      q_rgb.push_back('{cyc + 3, i, px, py, ev});
      if (inw) q_addr.push_back('{cyc + 1, i, px, py, {1'b0, ea}});
    end
    if (tick) model_tick(frz);
    @(posedge clk);
    #1;
  endtask

  task automatic scan_line(input int k, input int row, input bit frz);
    for (int px = X0 - 2; px < X0 + 8 * 11 + 2; px++) drive(px, Y0 + 16 * k + row, 1'b1, 1'b0, frz);
  endtask

  task automatic rand_pixels(input int n);
    for (int j = 0; j < n; j++)
      drive($urandom_range(180, 300), $urandom_range(200, 470), ($urandom_range(0, 9) != 0), 1'b0, 1'b0);
  endtask

  task automatic frame(input bit frz);
    drive(0, 0, 1'b0, 1'b1, frz);
    rand_pixels(8);
  endtask

  initial begin
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 16; k++) regs[i][k] = '0;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_rgb_w8", rgb0, 12'h000, 0, 0);
    check("reset_rgb_w32", rgb1, 12'h000, 0, 0);
    check("reset_addr_w8", {1'b0, rom_addr0}, 12'h000, 0, 0);
    rst_n = 1'b1;
    scan_line(2, 3, 1'b0);

    // First snapshot: no highlight, reg2 = A7, wide reg15 = DEADBEEF
    for (int k = 0; k < 16; k++) begin
      regs[0][k] = {24'b0, 8'($urandom())};
      regs[1][k] = $urandom();
    end
    regs[0][2]  = 32'hA7;
    regs[1][15] = 32'hDEADBEEF;
    frame(1'b0);
    scan_line(2, 0, 1'b0);
    scan_line(15, 7, 1'b0);

    // Changed register highlights for HOLD frames, then reverts
    regs[0][2] = 32'h3C;
    for (int f = 0; f < 32; f++) begin
      frame(1'b0);
      scan_line(2, f % 16, 1'b0);
    end

    // Freeze holds display; unfreeze shows new value highlighted
    regs[0][0] = 32'hFF;
    for (int f = 0; f < 3; f++) begin
      frame(1'b1);
      scan_line(0, 4, 1'b0);
    end
    frame(1'b0);
    scan_line(0, 4, 1'b1);

    // Window left edge and video_on blanking
    for (int px = X0 - 3; px <= X0 + 3; px++) drive(px, Y0 + 5, 1'b1, 1'b0, 1'b0);
    for (int px = X0 + 4; px <= X0 + 6; px++) drive(px, Y0 + 5, 1'b0, 1'b0, 1'b0);
    drive(X0 + 7, Y0 + 5, 1'b1, 1'b0, 1'b0);

    // Randomised frames with random changes and freeze
    for (int f = 0; f < 25; f++) begin
      for (int k = 0; k < 16; k++) begin
        if ($urandom_range(0, 3) == 0) regs[0][k] = {24'b0, 8'($urandom())};
        if ($urandom_range(0, 3) == 0) regs[1][k] = $urandom();
      end
      frame($urandom_range(0, 3) == 0);
      rand_pixels(12);
      scan_line($urandom_range(0, 7), $urandom_range(0, 15), 1'b0);
    end

    // Asynchronous reset mid-frame with live highlights
    regs[0][5] = regs[0][5] ^ 32'h1;
    regs[1][5] = regs[1][5] ^ 32'h1;
    frame(1'b0);
    scan_line(5, 2, 1'b0);
    #1;
    rst_n = 1'b0;
    q_rgb.delete();
    q_addr.delete();
    model_reset();
    #1;
    check("async_reset_rgb_w8", rgb0, 12'h000, 0, 0);
    check("async_reset_rgb_w32", rgb1, 12'h000, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    scan_line(5, 2, 1'b0);
    frame(1'b0);
    scan_line(5, 2, 1'b0);
    regs[0][5] = regs[0][5] ^ 32'h10;
    regs[1][5] = regs[1][5] ^ 32'h10;
    frame(1'b0);
    scan_line(5, 2, 1'b0);

    // Drain
    repeat (6) @(posedge clk);
    #1;
    if (q_rgb.size() + q_addr.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain pending=%0d want=0", q_rgb.size() + q_addr.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
